ua_transmitter_fifo: RTL and testbench
======================================

Name: ua_transmitter_fifo

Overview:
Parametrised UART transmitter, successor to the single-byte transmitter. It has configurable data width, parity and stop-bit count, plus an internal transmit FIFO that lets the host queue several characters. Bit timing comes from an external one-cycle baud tick ("enable"), one tick per bit period. It sits between a host write interface and the serial TX pin.

Parameters:
DATA_BITS, 8, character width, legal 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 4, TX FIFO entries, power of 2, at least 2
CW, clog2(FIFO_DEPTH+1), derived width of fifo_count

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-low reset
enable  in  1  baud tick, one clk wide, one per bit period
din_rdy  in  1  write strobe (level-sampled each clk, not edge-triggered)
din_data  in  DATA_BITS  character to queue
ovf_clr  in  1  clears the overflow flag
ser_out  out  1  serial TX line, idle high
uart_ready  out  1  1 when the FSM is IDLE and the FIFO is empty
fifo_full  out  1  FIFO holds FIFO_DEPTH entries
fifo_count  out  CW  number of queued entries
overflow  out  1  sticky; a write was attempted while full
busy  out  1  FSM is not IDLE

Behaviour:
- Reset (rst==0 at a clk edge):
  - ser_out=1, state=IDLE, FIFO flushed (fifo_count=0), overflow=0, fifo_full=0, busy=0, uart_ready=1.
  - Reset mid-frame aborts the frame; ser_out returns high on that edge.
- FIFO write:
  - Push on any clk where din_rdy=1 and fifo_full=0, independent of enable.
  - din_rdy=1 with fifo_full=1: data dropped, overflow<=1.
  - overflow holds until ovf_clr=1 or reset. If a set and a clear occur on the same edge, the set wins.
- FIFO pop:
  - Happens only on an enable tick per the FSM below.
  - A push and a pop on the same edge leave fifo_count unchanged.
  - A pop requires fifo_count>0 before the edge; there is no same-cycle bypass from din_data to the line.
  - fifo_full and fifo_count are registered and reflect post-edge contents.
- FSM: all transitions occur only on clk edges with enable=1. With enable=0, state, counters and ser_out hold. Each tick sets ser_out for the following bit period.
  - IDLE: if FIFO is not empty, pop into the shift register, ser_out<=0, go to START. Otherwise ser_out stays 1.
  - START: ser_out<=sr[0], shift right, bit_cnt<=1, go to DATA.
  - DATA: if bit_cnt<DATA_BITS, ser_out<=next LSB and bit_cnt++. Otherwise:
    - PARITY!=0: ser_out<=parity bit, go to PAR. Even parity = XOR of the data bits; odd parity = its inverse.
    - PARITY==0: ser_out<=1, stop_cnt<=0, go to STOP.
  - PAR: ser_out<=1, stop_cnt<=0, go to STOP.
  - STOP:
    - If stop_cnt<STOP_BITS-1: stop_cnt++, ser_out stays 1.
    - Otherwise, if FIFO is not empty: pop, ser_out<=0, go to START (back-to-back frame, no idle gap).
    - Otherwise: go to IDLE with ser_out=1.
- Frame length: 1+DATA_BITS+(PARITY?1:0)+STOP_BITS tick periods.
- Latency: first start bit appears at the first enable tick after the write is visible in the FIFO, i.e. at least 1 clk after the din_rdy edge.
- Parity is computed over the DATA_BITS bits popped from the FIFO and latched at pop.
- ser_out is driven directly from a flop (glitch-free).
- Illegal parameter values are rejected at elaboration.

Test Plan:
1. DATA_BITS=8, PARITY=1, STOP_BITS=1; write 0xA5, tick every 16 clk -> ser_out per tick: 0, 1,0,1,0,0,1,0,1, 0, 1; then uart_ready=1.
2. Same as 1 with PARITY=2 -> parity bit=1; with PARITY=0 -> 10-bit frame, no parity slot.
3. STOP_BITS=2; write 0x3C then 0xFF back-to-back -> two stop periods high, then start bit 0 on the next tick, no idle period between frames; fifo_count steps 2->1->0.
4. FIFO_DEPTH=4, enable=0; write 5 bytes on consecutive clks -> fifo_full=1 after the 4th, overflow=1 after the 5th, fifo_count=4. ovf_clr=1 -> overflow=0. With enable resumed, the 4 bytes are sent in order and the 5th is absent.
5. Assert rst=0 for one clk during the DATA bit 3 period -> next edge ser_out=1, fifo_count=0, busy=0, and no further frame bits are sent.
6. Hold enable=0 for 100 clk mid-DATA -> ser_out and state frozen; a din_rdy write during the freeze is still queued, so fifo_count increments.

Source files
------------

// File: rtl/ua_transmitter_fifo.sv
// UART transmitter with configurable framing and a transmit FIFO.
// Bit timing comes from an external one-cycle baud tick on enable.
module ua_transmitter_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 din_rdy,
  input  logic [DATA_BITS-1:0] din_data,
  input  logic                 ovf_clr,
  output logic                 ser_out,
  output logic                 uart_ready,
  output logic                 fifo_full,
  output logic [CW-1:0]        fifo_count,
  output logic                 overflow,
  output logic                 busy
);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      CW != $clog2(FIFO_DEPTH + 1)) begin : gen_param_check
    $error("ua_transmitter_fifo: illegal parameter value");
  end

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DepthC    = CW'(FIFO_DEPTH);
  localparam logic [3:0]    DataBitsC = 4'(DATA_BITS);
  localparam logic          StopLastC = 1'(STOP_BITS - 1);
  localparam logic          ParOddC   = (PARITY == 2);
  localparam logic          ParEnC    = (PARITY != 0);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StPar   = 3'd3;
  localparam logic [2:0] StStop  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 par_q, par_d;
  logic                 ser_q, ser_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 full_q, full_d;
  logic                 ovf_q, ovf_d;
  logic                 push, pop, fifo_empty;
  logic [DATA_BITS-1:0] head;

  assign fifo_empty = (count_q == '0);
  assign push       = din_rdy && !full_q;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    ser_d      = ser_q;
    pop        = 1'b0;
    if (enable) begin
      unique case (state_q)
        StIdle: begin
          ser_d = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            sr_d    = head;
            par_d   = (^head) ^ ParOddC;
            ser_d   = 1'b0;
            state_d = StStart;
          end
        end
        StStart: begin
          ser_d     = sr_q[0];
          sr_d      = sr_q >> 1;
          bit_cnt_d = 4'd1;
          state_d   = StData;
        end
        StData: begin
          if (bit_cnt_q < DataBitsC) begin
            ser_d     = sr_q[0];
            sr_d      = sr_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (ParEnC) begin
            ser_d   = par_q;
            state_d = StPar;
          end else begin
            ser_d      = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = StStop;
          end
        end
        StPar: begin
          ser_d      = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = StStop;
        end
        StStop: begin
          ser_d = 1'b1;
          if (stop_cnt_q < StopLastC) begin
            stop_cnt_d = 1'b1;
          end else if (!fifo_empty) begin
            // Back-to-back frame: the next start bit replaces the idle gap.
            pop     = 1'b1;
            sr_d    = head;
            par_d   = (^head) ^ ParOddC;
            ser_d   = 1'b0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
        default: begin
          ser_d   = 1'b1;
          state_d = StIdle;
        end
      endcase
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    full_d = (count_d == DepthC);
    // A dropped write outranks a simultaneous clear.
    if (din_rdy && full_q) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      ser_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      ser_q      <= ser_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ser_out    = ser_q;
  assign busy       = (state_q != StIdle);
  assign uart_ready = !busy && fifo_empty;
  assign fifo_full  = full_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ua_transmitter_fifo.sv
// Directed bench: instance a is 8E2, instance b is 8O1; both share stimulus.
module tb_ua_transmitter_fifo;

  logic       clk = 1'b0;
  logic       rst, enable, din_rdy, ovf_clr;
  logic [7:0] din_data;

  logic       ser_a, rdy_a, full_a, ovf_a, busy_a;
  logic [2:0] cnt_a;
  logic       ser_b, rdy_b, full_b, ovf_b, busy_b;
  logic [2:0] cnt_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ua_transmitter_fifo #(
    .DATA_BITS (8),
    .PARITY    (1),
    .STOP_BITS (2),
    .FIFO_DEPTH(4)
  ) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .din_rdy   (din_rdy),
    .din_data  (din_data),
    .ovf_clr   (ovf_clr),
    .ser_out   (ser_a),
    .uart_ready(rdy_a),
    .fifo_full (full_a),
    .fifo_count(cnt_a),
    .overflow  (ovf_a),
    .busy      (busy_a)
  );

  ua_transmitter_fifo #(
    .DATA_BITS (8),
    .PARITY    (2),
    .STOP_BITS (1),
    .FIFO_DEPTH(4)
  ) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .din_rdy   (din_rdy),
    .din_data  (din_data),
    .ovf_clr   (ovf_clr),
    .ser_out   (ser_b),
    .uart_ready(rdy_b),
    .fifo_full (full_b),
    .fifo_count(cnt_b),
    .overflow  (ovf_b),
    .busy      (busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    enable = 1'b1;
    clk1();
    enable = 1'b0;
    repeat (2) clk1();
  endtask

  task automatic write(input logic [7:0] d);
    din_rdy  = 1'b1;
    din_data = d;
    clk1();
    din_rdy  = 1'b0;
  endtask

  // Expected 8E2 frame on instance a: start, LSB-first data, even parity, two stops.
  task automatic frame_a(input string tag, input logic [7:0] d);
    logic [11:0] e;
    e[0]   = 1'b0;
    e[8:1] = d;
    e[9]   = ^d;
    e[10]  = 1'b1;
    e[11]  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk(tag, 32'(ser_a), 32'(e[i]));
    end
  endtask

  initial begin
    logic [0:11] exp_a1, exp_b1;
    logic [0:23] exp_a3;
    logic [7:0]  bytes4 [5];
    logic [0:7]  exp_a6;

    rst      = 1'b0;
    enable   = 1'b0;
    din_rdy  = 1'b0;
    ovf_clr  = 1'b0;
    din_data = '0;
    repeat (2) clk1();
    chk("rst_ser", 32'(ser_a), 1);
    chk("rst_cnt", 32'(cnt_a), 0);
    chk("rst_full", 32'(full_a), 0);
    chk("rst_ovf", 32'(ovf_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_rdy", 32'(rdy_a), 1);
    rst = 1'b1;
    clk1();

    // 0xA5 through even-parity/2-stop (a) and odd-parity/1-stop (b).
    exp_a1 = 12'b0_10100101_0_11;
    exp_b1 = 12'b0_10100101_1_11;
    write(8'hA5);
    chk("t1_cnt", 32'(cnt_a), 1);
    chk("t1_rdy_pre", 32'(rdy_a), 0);
    chk("t1_busy_pre", 32'(busy_a), 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t1_ser_a", 32'(ser_a), 32'(exp_a1[i]));
      chk("t1_ser_b", 32'(ser_b), 32'(exp_b1[i]));
      if (i == 0) begin
        chk("t1_busy", 32'(busy_a), 1);
        chk("t1_cnt_pop", 32'(cnt_a), 0);
      end
    end
    chk("t1_rdy_b", 32'(rdy_b), 1);
    chk("t1_busy_a_stop2", 32'(busy_a), 1);
    tick();
    chk("t1_rdy_a", 32'(rdy_a), 1);
    chk("t1_idle_ser_a", 32'(ser_a), 1);
    repeat (12) tick();

    // Back-to-back frames 0x3C then 0xFF with two stop bits, no idle gap.
    exp_a3 = 24'b0_00111100_0_11_0_11111111_0_11;
    write(8'h3C);
    write(8'hFF);
    chk("t3_cnt2", 32'(cnt_a), 2);
    for (int i = 0; i < 24; i++) begin
      tick();
      chk("t3_ser", 32'(ser_a), 32'(exp_a3[i]));
      if (i == 0) chk("t3_cnt1", 32'(cnt_a), 1);
      if (i == 12) chk("t3_cnt0", 32'(cnt_a), 0);
    end
    tick();
    chk("t3_rdy", 32'(rdy_a), 1);
    repeat (12) tick();

    // Fill with enable low, overflow on the 5th write, then drain.
    bytes4[0] = 8'h11;
    bytes4[1] = 8'h22;
    bytes4[2] = 8'h33;
    bytes4[3] = 8'h44;
    bytes4[4] = 8'h55;
    for (int i = 0; i < 5; i++) begin
      din_rdy  = 1'b1;
      din_data = bytes4[i];
      clk1();
      chk("t4_full", 32'(full_a), (i >= 3) ? 1 : 0);
      chk("t4_cnt", 32'(cnt_a), (i >= 3) ? 4 : i + 1);
      chk("t4_ovf", 32'(ovf_a), (i == 4) ? 1 : 0);
    end
    din_rdy = 1'b0;
    ovf_clr = 1'b1;
    clk1();
    chk("t4_ovf_clr", 32'(ovf_a), 0);
    din_rdy  = 1'b1;
    din_data = 8'h66;
    clk1();
    chk("t4_set_wins", 32'(ovf_a), 1);
    din_rdy = 1'b0;
    clk1();
    ovf_clr = 1'b0;
    chk("t4_ovf_clr2", 32'(ovf_a), 0);
    chk("t4_cnt_hold", 32'(cnt_a), 4);
    for (int i = 0; i < 4; i++) frame_a("t4_frame", bytes4[i]);
    tick();
    chk("t4_no5th_ser", 32'(ser_a), 1);
    chk("t4_rdy", 32'(rdy_a), 1);
    repeat (12) tick();

    // Reset during data bit 3 of 0x52 (bits LSB-first 0,1,0,0,...).
    write(8'h52);
    write(8'h77);
    for (int i = 0; i < 5; i++) tick();
    chk("t5_bit3", 32'(ser_a), 0);
    chk("t5_cnt_pre", 32'(cnt_a), 1);
    rst = 1'b0;
    clk1();
    rst = 1'b1;
    chk("t5_ser", 32'(ser_a), 1);
    chk("t5_cnt", 32'(cnt_a), 0);
    chk("t5_busy", 32'(busy_a), 0);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("t5_quiet_ser", 32'(ser_a), 1);
      chk("t5_quiet_busy", 32'(busy_a), 0);
    end

    // Freeze mid-data on 0xC3 (data bit 2 = 0) with a write during the freeze.
    write(8'hC3);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_pre", 32'(ser_a), 0);
    for (int k = 0; k < 100; k++) begin
      din_rdy  = (k == 50);
      din_data = 8'h81;
      clk1();
      if (k % 20 == 0) begin
        chk("t6_frz_ser", 32'(ser_a), 0);
        chk("t6_frz_busy", 32'(busy_a), 1);
      end
    end
    din_rdy = 1'b0;
    chk("t6_cnt", 32'(cnt_a), 1);
    exp_a6 = 8'b00011011;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t6_resume", 32'(ser_a), 32'(exp_a6[i]));
    end
    frame_a("t6_frame2", 8'h81);
    tick();
    chk("t6_rdy", 32'(rdy_a), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
